// File: rtl/psimd_pkg.sv
// Shared constants and mode encodings for the packed-SIMD saturating adder.
package psimd_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 16;
  localparam int unsigned DEFAULT_LANE_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic {
    SAT_SIGNED   = 1'b0,
    SAT_UNSIGNED = 1'b1
  } sat_mode_e;

endpackage

// File: rtl/psimd_lane_sat.sv
// One lane: add/sub with signed or unsigned saturation and a saturation flag.
module psimd_lane_sat
  import psimd_pkg::*;
#(
  parameter int unsigned LANE_W = DEFAULT_LANE_W
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  op_e               op,
  input  sat_mode_e         mode,
  output logic [LANE_W-1:0] sum_c,
  output logic              sat_c
);

  localparam int unsigned EXT_W = LANE_W + 1;

  logic [EXT_W-1:0] a_x;
  logic [EXT_W-1:0] b_x;
  logic [EXT_W-1:0] r_x;

  // One guard bit: carry/borrow in unsigned mode, overflow detect in signed mode.
  always_comb begin
    a_x   = (mode == SAT_UNSIGNED) ? {1'b0, a} : {a[LANE_W-1], a};
    b_x   = (mode == SAT_UNSIGNED) ? {1'b0, b} : {b[LANE_W-1], b};
    r_x   = (op == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    sum_c = r_x[LANE_W-1:0];
    sat_c = 1'b0;
    if (mode == SAT_UNSIGNED) begin
      if (r_x[LANE_W]) begin
        sat_c = 1'b1;
        sum_c = (op == OP_SUB) ? '0 : '1;
      end
    end else if (r_x[LANE_W] != r_x[LANE_W-1]) begin
      sat_c = 1'b1;
      sum_c = {r_x[LANE_W], {(LANE_W-1){~r_x[LANE_W]}}};
    end
  end

endmodule

// File: rtl/psimd_addsat.sv
// Two-stage packed-SIMD saturating add/sub with valid/ready flow control
// and sticky per-lane saturation flags.
module psimd_addsat
  import psimd_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned LANE_W = DEFAULT_LANE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic                      in_sub,
  input  logic                      in_uns,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_sum,
  output logic [WIDTH/LANE_W-1:0]   out_sat,
  output logic [WIDTH/LANE_W-1:0]   sat_sticky,
  input  logic                      sat_clr
);

  localparam int unsigned LANES = WIDTH / LANE_W;

  if (((WIDTH % LANE_W) != 0) || (LANE_W < 2)) begin : g_bad_cfg
    $error("psimd_addsat: WIDTH must be a multiple of LANE_W and LANE_W must be >= 2");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;
  sat_mode_e        s1_mode_q, s1_mode_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [LANES-1:0] out_sat_q, out_sat_d;
  logic [LANES-1:0] sticky_q, sticky_d;

  logic [WIDTH-1:0] lane_sum_c;
  logic [LANES-1:0] lane_sat_c;
  logic             s2_load_c;
  logic             s1_load_c;
  logic             out_xfer_c;

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    psimd_lane_sat #(
      .LANE_W (LANE_W)
    ) u_lane (
      .a     (s1_a_q[i*LANE_W +: LANE_W]),
      .b     (s1_b_q[i*LANE_W +: LANE_W]),
      .op    (s1_op_q),
      .mode  (s1_mode_q),
      .sum_c (lane_sum_c[i*LANE_W +: LANE_W]),
      .sat_c (lane_sat_c[i])
    );
  end

  // Each stage refills when empty or when its contents move on this edge.
  assign out_xfer_c = out_valid_q & out_ready;
  assign s2_load_c  = ~out_valid_q | out_ready;
  assign s1_load_c  = ~s1_valid_q | s2_load_c;
  assign in_ready   = s1_load_c;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    sticky_d    = sticky_q;

    if (s1_load_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = in_a;
        s1_b_d    = in_b;
        s1_op_d   = op_e'(in_sub);
        s1_mode_d = sat_mode_e'(in_uns);
      end
    end

    if (s2_load_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sum_d = lane_sum_c;
        out_sat_d = lane_sat_c;
      end
    end

    // Clear first so a coincident transfer leaves exactly its own flags.
    if (sat_clr) begin
      sticky_d = '0;
    end
    if (out_xfer_c) begin
      sticky_d = sticky_d | out_sat_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_ADD;
      s1_mode_q   <= SAT_SIGNED;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= '0;
      sticky_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_sat    = out_sat_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_psimd_addsat.sv
// Directed-vector bench for psimd_addsat (WIDTH=16, LANE_W=4).
module tb_psimd_addsat;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic        in_uns;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [3:0]  out_sat;
  logic [3:0]  sat_sticky;
  logic        sat_clr;

  int total = 0;
  int bad   = 0;

  psimd_addsat #(.WIDTH(16), .LANE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .in_uns     (in_uns),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_sat    (out_sat),
    .sat_sticky (sat_sticky),
    .sat_clr    (sat_clr)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    in_uns = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_sum !== 16'h0000) begin bad++; $display("FAIL rst_out_sum got=%h exp=0000", out_sum); end
    total++; if (out_sat !== 4'b0000) begin bad++; $display("FAIL rst_out_sat got=%b exp=0000", out_sat); end
    total++; if (sat_sticky !== 4'b0000) begin bad++; $display("FAIL rst_sticky got=%b exp=0000", sat_sticky); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_idle_valid got=%b exp=0", out_valid); end
  endtask

  // Four arithmetic modes, one word at a time, with latency and sticky accumulation.
  task automatic test_arith();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vs [4];
    logic        vu [4];
    logic [15:0] es [4];
    logic [3:0]  ef [4];
    va[0] = 16'h783F; vb[0] = 16'h1821; vs[0] = 1'b0; vu[0] = 1'b0; es[0] = 16'h7850; ef[0] = 4'b1100;
    va[1] = 16'h783F; vb[1] = 16'h1821; vs[1] = 1'b0; vu[1] = 1'b1; es[1] = 16'h8F5F; ef[1] = 4'b0101;
    va[2] = 16'h250F; vb[2] = 16'h311F; vs[2] = 1'b1; vu[2] = 1'b1; es[2] = 16'h0400; ef[2] = 4'b1010;
    va[3] = 16'h8700; vb[3] = 16'h1F81; vs[3] = 1'b1; vu[3] = 1'b0; es[3] = 16'h877F; ef[3] = 4'b1110;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = va[i]; in_b = vb[i]; in_sub = vs[i]; in_uns = vu[i]; in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arith%0d_in_ready got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arith%0d_lat1 got=%b exp=0", i, out_valid); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arith%0d_lat2 got=%b exp=1", i, out_valid); end
      total++; if (out_sum !== es[i]) begin bad++; $display("FAIL arith%0d_sum got=%h exp=%h", i, out_sum, es[i]); end
      total++; if (out_sat !== ef[i]) begin bad++; $display("FAIL arith%0d_sat got=%b exp=%b", i, out_sat, ef[i]); end
    end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arith_drain got=%b exp=0", out_valid); end
    total++; if (sat_sticky !== 4'b1111) begin bad++; $display("FAIL arith_sticky got=%b exp=1111", sat_sticky); end
  endtask

  task automatic test_sticky();
    out_ready = 1'b1;
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    total++; if (sat_sticky !== 4'b0000) begin bad++; $display("FAIL clr_alone got=%b exp=0000", sat_sticky); end
    in_a = 16'h783F; in_b = 16'h1821; in_sub = 1'b0; in_uns = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_uns = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (sat_sticky !== 4'b1100) begin bad++; $display("FAIL sticky_first got=%b exp=1100", sat_sticky); end
    total++; if (out_sat !== 4'b0101) begin bad++; $display("FAIL sticky_second_sat got=%b exp=0101", out_sat); end
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    total++; if (sat_sticky !== 4'b0101) begin bad++; $display("FAIL clr_with_xfer got=%b exp=0101", sat_sticky); end
  endtask

  task automatic test_backpressure();
    logic [15:0] wa [3];
    logic [15:0] wb [3];
    logic        ws [3];
    logic        wu [3];
    logic [15:0] es [3];
    logic [3:0]  ef [3];
    logic        exp_rdy [4];
    int          idx;
    int          k;
    logic        rdy;
    logic        ov;
    logic [15:0] osum;
    logic [3:0]  osat;
    wa[0] = 16'h783F; wb[0] = 16'h1821; ws[0] = 1'b0; wu[0] = 1'b0; es[0] = 16'h7850; ef[0] = 4'b1100;
    wa[1] = 16'h783F; wb[1] = 16'h1821; ws[1] = 1'b0; wu[1] = 1'b1; es[1] = 16'h8F5F; ef[1] = 4'b0101;
    wa[2] = 16'h250F; wb[2] = 16'h311F; ws[2] = 1'b1; wu[2] = 1'b1; es[2] = 16'h0400; ef[2] = 4'b1010;
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0; exp_rdy[3] = 1'b0;
    idx = 0;
    k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_a = wa[idx]; in_b = wb[idx]; in_sub = ws[idx]; in_uns = wu[idx]; in_valid = 1'b1;
      #1;
      rdy = in_ready;
      total++; if (rdy !== exp_rdy[c]) begin bad++; $display("FAIL bp_ready_c%0d got=%b exp=%b", c, rdy, exp_rdy[c]); end
      if (c >= 2) begin
        total++; if (out_sum !== 16'h7850 || out_valid !== 1'b1) begin
          bad++; $display("FAIL bp_hold_c%0d got=%h/%b exp=7850/1", c, out_sum, out_valid);
        end
      end
      @(posedge clk); #1;
      if (rdy === 1'b1) idx++;
    end
    total++; if (idx !== 2) begin bad++; $display("FAIL bp_accepted got=%0d exp=2", idx); end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && k < 3; c++) begin
      if (idx < 3) begin
        in_a = wa[idx]; in_b = wb[idx]; in_sub = ws[idx]; in_uns = wu[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      rdy = in_ready; ov = out_valid; osum = out_sum; osat = out_sat;
      @(posedge clk); #1;
      if (rdy === 1'b1 && idx < 3) idx++;
      if (ov === 1'b1) begin
        total++; if (osum !== es[k] || osat !== ef[k]) begin
          bad++; $display("FAIL bp_out%0d got=%h/%b exp=%h/%b", k, osum, osat, es[k], ef[k]);
        end
        k++;
      end
    end
    in_valid = 1'b0;
    total++; if (k !== 3) begin bad++; $display("FAIL bp_out_count got=%0d exp=3", k); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_extra_out got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_flight();
    out_ready = 1'b0;
    in_a = 16'h8700; in_b = 16'h1F81; in_sub = 1'b1; in_uns = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'h250F; in_b = 16'h311F; in_uns = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rf_loaded got=%b exp=1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_async_valid got=%b exp=0", out_valid); end
    total++; if (out_sum !== 16'h0000 || out_sat !== 4'b0000) begin
      bad++; $display("FAIL rf_async_data got=%h/%b exp=0000/0000", out_sum, out_sat);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rf_in_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_stale_c%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_sticky();
    test_backpressure();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
